// File: rtl/rggen_rtl_pkg.sv
// -----------------------------------------------------------------------------
// rggen_rtl_pkg
//   Shared types for the native bus adapter and the register blocks behind it.
//   - rggen_status_t    : response status reported back to the host
//   - rggen_access_t    : direction of a register access
//   - rggen_bus_state_t : adapter FSM state
// -----------------------------------------------------------------------------
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    OKAY         = 2'b00,
    EXOKAY       = 2'b01,
    SLAVE_ERROR  = 2'b10,
    DECODE_ERROR = 2'b11
  } rggen_status_t;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_access_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    RESPOND = 2'b10
  } rggen_bus_state_t;

endpackage

// File: rtl/rggen_native_bus_adapter_if.sv
// -----------------------------------------------------------------------------
// rggen_native_bus_adapter_if
//   Bundles the host request/response channels and the flat register bus.
//   - req_*     : host request channel (valid/ready)
//   - rsp_*     : host response channel (valid/ready)
//   - reg_*     : register bus towards the register blocks and their
//                 aggregated match/ready/status/read-data returns
//   Modports:
//   - master : host plus register-block side (drives requests and returns)
//   - slave  : adapter side
// -----------------------------------------------------------------------------
interface rggen_native_bus_adapter_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [ADDRESS_WIDTH-1:0] req_address;
  logic [BUS_WIDTH-1:0]     req_write_data;
  logic [BUS_WIDTH/8-1:0]   req_strobe;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [1:0]               rsp_status;
  logic [BUS_WIDTH-1:0]     rsp_read_data;

  logic                     reg_valid;
  logic                     reg_write;
  logic [ADDRESS_WIDTH-1:0] reg_address;
  logic [BUS_WIDTH-1:0]     reg_write_data;
  logic [BUS_WIDTH/8-1:0]   reg_strobe;
  logic                     reg_match;
  logic                     reg_ready;
  logic [1:0]               reg_status;
  logic [BUS_WIDTH-1:0]     reg_read_data;

  modport master (
    output req_valid, req_write, req_address, req_write_data, req_strobe,
    output rsp_ready,
    output reg_match, reg_ready, reg_status, reg_read_data,
    input  req_ready, rsp_valid, rsp_status, rsp_read_data,
    input  reg_valid, reg_write, reg_address, reg_write_data, reg_strobe
  );

  modport slave (
    input  req_valid, req_write, req_address, req_write_data, req_strobe,
    input  rsp_ready,
    input  reg_match, reg_ready, reg_status, reg_read_data,
    output req_ready, rsp_valid, rsp_status, rsp_read_data,
    output reg_valid, reg_write, reg_address, reg_write_data, reg_strobe
  );

endinterface

// File: rtl/rggen_bus_timeout_counter.sv
// -----------------------------------------------------------------------------
// rggen_bus_timeout_counter
//   Counts wait cycles of one register access and flags when the access has
//   waited TIMEOUT_CYCLES cycles. TIMEOUT_CYCLES = 0 disables the flag.
//   Ports:
//   - i_clk, i_rst : clock, synchronous active-high reset
//   - enable       : count this cycle
//   - clear        : return to zero (wins over enable)
//   - expired      : count has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module rggen_bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
)(
  input  logic i_clk,
  input  logic i_rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int COUNT_WIDTH =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [COUNT_WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_clk) begin
    if (i_rst || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      // Saturate instead of wrapping so a long wait can never look fresh.
      count <= count + 1'b1;
    end
  end

  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    assign expired = (count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_timeout
    assign expired = 1'b0;
  end

endmodule

// File: rtl/rggen_native_bus_adapter.sv
// -----------------------------------------------------------------------------
// rggen_native_bus_adapter
//   Accepts one host request at a time, drives it onto the flat register bus,
//   resolves the aggregated return (decode error, ready, timeout) and hands a
//   buffered response back to the host.
//   Ports:
//   - i_clk, i_rst : clock, synchronous active-high reset
//   - bus          : host request/response channels and register bus
// -----------------------------------------------------------------------------
module rggen_native_bus_adapter
  import rggen_rtl_pkg::*;
#(
  parameter int                   ADDRESS_WIDTH   = 8,
  parameter int                   BUS_WIDTH       = 32,
  parameter int                   TIMEOUT_CYCLES  = 64,
  parameter logic [BUS_WIDTH-1:0] ERROR_READ_DATA = '0
)(
  input logic                        i_clk,
  input logic                        i_rst,
  rggen_native_bus_adapter_if.slave  bus
);

  localparam int STROBE_WIDTH = BUS_WIDTH / 8;
  localparam int ADDRESS_LSB  = $clog2(STROBE_WIDTH);
  localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_MASK =
    ADDRESS_WIDTH'((1 << ADDRESS_LSB) - 1);

  rggen_bus_state_t         state;
  rggen_bus_state_t         state_next;
  rggen_access_t            access;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [STROBE_WIDTH-1:0]  strobe;
  rggen_status_t            rsp_status;
  logic [BUS_WIDTH-1:0]     rsp_read_data;

  logic                     done;
  rggen_status_t            done_status;
  logic [BUS_WIDTH-1:0]     done_read_data;
  logic                     expired;
  logic                     in_access;
  logic                     req_ready;
  logic                     reg_valid;
  logic                     rsp_valid;

  assign in_access = (state == ACCESS);

  // Resolve the register return for the current ACCESS cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    done           = 1'b0;
    done_status    = OKAY;
    done_read_data = '0;
    if (in_access) begin
      if (!bus.reg_match) begin
        // A ready without a match is still a decode error.
        done           = 1'b1;
        done_status    = DECODE_ERROR;
        done_read_data = ERROR_READ_DATA;
      end else if (bus.reg_ready) begin
        done           = 1'b1;
        done_status    = rggen_status_t'(bus.reg_status);
        done_read_data = (access == RGGEN_WRITE) ? '0 : bus.reg_read_data;
      end else if (expired) begin
        done           = 1'b1;
        done_status    = SLAVE_ERROR;
        done_read_data = ERROR_READ_DATA;
      end
    end
  end

  rggen_bus_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .enable  (in_access && !done),
    .clear   (!in_access || done),
    .expired (expired)
  );

  // FSM: state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.req_valid) state_next = ACCESS;
      ACCESS:  if (done)          state_next = RESPOND;
      RESPOND: if (bus.rsp_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // FSM: outputs. Handshake flags decode straight from the state, so the
  // response handshake cycle never overlaps a request acceptance.
  always_comb begin
    req_ready = 1'b0;
    reg_valid = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE:    req_ready = 1'b1;
      ACCESS:  reg_valid = 1'b1;
      RESPOND: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request capture and response buffer. Reset discards any pending result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      access        <= RGGEN_READ;
      address       <= '0;
      write_data    <= '0;
      strobe        <= '0;
      rsp_status    <= OKAY;
      rsp_read_data <= '0;
    end else begin
      if ((state == IDLE) && bus.req_valid) begin
        access     <= bus.req_write ? RGGEN_WRITE : RGGEN_READ;
        address    <= bus.req_address & ~ADDRESS_MASK;
        write_data <= bus.req_write_data;
        strobe     <= bus.req_write ? bus.req_strobe : '1;
      end
      if (done) begin
        rsp_status    <= done_status;
        rsp_read_data <= done_read_data;
      end
    end
  end

  assign bus.req_ready      = req_ready;
  assign bus.rsp_valid      = rsp_valid;
  assign bus.rsp_status     = rsp_status;
  assign bus.rsp_read_data  = rsp_read_data;
  assign bus.reg_valid      = reg_valid;
  assign bus.reg_write      = (access == RGGEN_WRITE);
  assign bus.reg_address    = address;
  assign bus.reg_write_data = write_data;
  assign bus.reg_strobe     = strobe;

endmodule

// File: tb/tb_rggen_native_bus_adapter.sv
// -----------------------------------------------------------------------------
// tb_rggen_native_bus_adapter
//   Two adapters share one stimulus set: dut_t4 (TIMEOUT_CYCLES=4, non-zero
//   error data) and dut_t0 (timeout disabled). 'sel' routes the handshakes and
//   selects which adapter's outputs are observed. Expected responses come from
//   a transaction-level model: decode error, ready arrival or timeout decides
//   status, data and the number of cycles the access stays on the bus.
// -----------------------------------------------------------------------------
module tb_rggen_native_bus_adapter;

  localparam int AW   = 8;
  localparam int BW   = 32;
  localparam int SW   = BW / 8;
  localparam int TO_A = 4;
  localparam int TO_B = 0;
  localparam logic [BW-1:0] ERR_A = 32'hBAD0_0BAD;
  localparam logic [BW-1:0] ERR_B = '0;

  typedef struct {
    logic          write;
    logic [AW-1:0] address;
    logic [BW-1:0] write_data;
    logic [SW-1:0] strobe;
    logic          match;
    int            ready_at;   // ACCESS cycle (1-based) where ready rises
    logic [1:0]    status;
    logic [BW-1:0] read_data;
  } txn_t;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  logic          sel;
  logic          req_valid, req_write;
  logic [AW-1:0] req_address;
  logic [BW-1:0] req_write_data;
  logic [SW-1:0] req_strobe;
  logic          rsp_ready;
  logic          reg_match, reg_ready;
  logic [1:0]    reg_status;
  logic [BW-1:0] reg_read_data;

  rggen_native_bus_adapter_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bus_a ();
  rggen_native_bus_adapter_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bus_b ();

  assign bus_a.req_valid      = req_valid & ~sel;
  assign bus_a.rsp_ready      = rsp_ready & ~sel;
  assign bus_a.req_write      = req_write;
  assign bus_a.req_address    = req_address;
  assign bus_a.req_write_data = req_write_data;
  assign bus_a.req_strobe     = req_strobe;
  assign bus_a.reg_match      = reg_match;
  assign bus_a.reg_ready      = reg_ready;
  assign bus_a.reg_status     = reg_status;
  assign bus_a.reg_read_data  = reg_read_data;

  assign bus_b.req_valid      = req_valid & sel;
  assign bus_b.rsp_ready      = rsp_ready & sel;
  assign bus_b.req_write      = req_write;
  assign bus_b.req_address    = req_address;
  assign bus_b.req_write_data = req_write_data;
  assign bus_b.req_strobe     = req_strobe;
  assign bus_b.reg_match      = reg_match;
  assign bus_b.reg_ready      = reg_ready;
  assign bus_b.reg_status     = reg_status;
  assign bus_b.reg_read_data  = reg_read_data;

  rggen_native_bus_adapter #(
    .ADDRESS_WIDTH (AW), .BUS_WIDTH (BW),
    .TIMEOUT_CYCLES (TO_A), .ERROR_READ_DATA (ERR_A)
  ) dut_t4 (
    .i_clk (i_clk), .i_rst (i_rst), .bus (bus_a.slave)
  );

  rggen_native_bus_adapter #(
    .ADDRESS_WIDTH (AW), .BUS_WIDTH (BW),
    .TIMEOUT_CYCLES (TO_B), .ERROR_READ_DATA (ERR_B)
  ) dut_t0 (
    .i_clk (i_clk), .i_rst (i_rst), .bus (bus_b.slave)
  );

  logic          obs_req_ready, obs_rsp_valid, obs_reg_valid, obs_reg_write;
  logic [1:0]    obs_rsp_status;
  logic [BW-1:0] obs_rsp_read_data, obs_reg_write_data;
  logic [AW-1:0] obs_reg_address;
  logic [SW-1:0] obs_reg_strobe;

  assign obs_req_ready      = sel ? bus_b.req_ready      : bus_a.req_ready;
  assign obs_rsp_valid      = sel ? bus_b.rsp_valid      : bus_a.rsp_valid;
  assign obs_reg_valid      = sel ? bus_b.reg_valid      : bus_a.reg_valid;
  assign obs_reg_write      = sel ? bus_b.reg_write      : bus_a.reg_write;
  assign obs_rsp_status     = sel ? bus_b.rsp_status     : bus_a.rsp_status;
  assign obs_rsp_read_data  = sel ? bus_b.rsp_read_data  : bus_a.rsp_read_data;
  assign obs_reg_write_data = sel ? bus_b.reg_write_data : bus_a.reg_write_data;
  assign obs_reg_address    = sel ? bus_b.reg_address    : bus_a.reg_address;
  assign obs_reg_strobe     = sel ? bus_b.reg_strobe     : bus_a.reg_strobe;

  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "reset";
  txn_t  t, nxt, none;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", phase, tag, observed, expected);
    end
  endtask

  function automatic txn_t mk(input logic write, input logic [AW-1:0] address,
                              input logic [BW-1:0] write_data, input logic [SW-1:0] strobe,
                              input logic match, input int ready_at,
                              input logic [1:0] status, input logic [BW-1:0] read_data);
    txn_t r;
    r.write = write; r.address = address; r.write_data = write_data;
    r.strobe = strobe; r.match = match; r.ready_at = ready_at;
    r.status = status; r.read_data = read_data;
    return r;
  endfunction

  // Transaction-level reference: how long the access stays on the bus and
  // what the host gets back.
  function automatic void model(input txn_t x, input int timeout, input logic [BW-1:0] err,
                                output int cycles, output logic [1:0] status,
                                output logic [BW-1:0] data);
    if (!x.match) begin
      cycles = 1; status = 2'b11; data = err;
    end else if (timeout == 0 || x.ready_at <= timeout) begin
      cycles = x.ready_at; status = x.status; data = x.write ? '0 : x.read_data;
    end else begin
      cycles = timeout; status = 2'b10; data = err;
    end
  endfunction

  task automatic check_reset_state();
    check("rst_req_ready", obs_req_ready, 1'b1);
    check("rst_rsp_valid", obs_rsp_valid, 1'b0);
    check("rst_reg_valid", obs_reg_valid, 1'b0);
    check("rst_reg_write", obs_reg_write, 1'b0);
    check("rst_reg_address", obs_reg_address, '0);
    check("rst_reg_write_data", obs_reg_write_data, '0);
    check("rst_reg_strobe", obs_reg_strobe, '0);
    check("rst_rsp_status", obs_rsp_status, 2'b00);
    check("rst_rsp_read_data", obs_rsp_read_data, '0);
  endtask

  // Present the request, wait (bounded) for acceptance, return in the first
  // ACCESS cycle with the host inputs scrambled.
  task automatic drive_req(input txn_t x);
    req_write = x.write; req_address = x.address;
    req_write_data = x.write_data; req_strobe = x.strobe; req_valid = 1'b1;
    for (int w = 0; w < 50 && obs_req_ready !== 1'b1; w++) @(negedge i_clk);
    check("req_ready_wait", obs_req_ready, 1'b1);
    @(negedge i_clk);
    req_valid = 1'b0;
    req_write = 1'($urandom); req_address = AW'($urandom);
    req_write_data = BW'($urandom); req_strobe = SW'($urandom);
    reg_match = x.match; reg_status = x.status; reg_read_data = x.read_data;
  endtask

  task automatic access_phase(input txn_t x, output int cycles);
    logic [AW-1:0] exp_address;
    logic [SW-1:0] exp_strobe;
    exp_address = AW'((int'(x.address) / SW) * SW);
    exp_strobe  = x.write ? x.strobe : '1;
    cycles = 0;
    while (obs_rsp_valid !== 1'b1 && cycles < 300) begin
      cycles++;
      check("reg_valid", obs_reg_valid, 1'b1);
      check("req_ready_busy", obs_req_ready, 1'b0);
      check("reg_write", obs_reg_write, x.write);
      check("reg_address", obs_reg_address, exp_address);
      check("reg_write_data", obs_reg_write_data, x.write_data);
      check("reg_strobe", obs_reg_strobe, exp_strobe);
      reg_ready = (cycles >= x.ready_at);
      @(negedge i_clk);
    end
  endtask

  task automatic respond(input logic [1:0] status, input logic [BW-1:0] data,
                         input int delay, input bit queue, input txn_t q);
    check("rsp_valid", obs_rsp_valid, 1'b1);
    check("reg_valid_drop", obs_reg_valid, 1'b0);
    check("rsp_status", obs_rsp_status, status);
    check("rsp_read_data", obs_rsp_read_data, data);
    check("req_ready_rsp", obs_req_ready, 1'b0);
    reg_match = 1'($urandom); reg_ready = 1'($urandom);
    if (queue) begin
      req_write = q.write; req_address = q.address;
      req_write_data = q.write_data; req_strobe = q.strobe; req_valid = 1'b1;
    end
    for (int d = 0; d < delay; d++) begin
      rsp_ready = 1'b0;
      @(negedge i_clk);
      check("rsp_hold_valid", obs_rsp_valid, 1'b1);
      check("rsp_hold_status", obs_rsp_status, status);
      check("rsp_hold_data", obs_rsp_read_data, data);
      check("rsp_hold_req_ready", obs_req_ready, 1'b0);
      reg_status = 2'($urandom); reg_read_data = BW'($urandom);
    end
    rsp_ready = 1'b1;
    @(negedge i_clk);
    rsp_ready = 1'b0;
    check("rsp_valid_clear", obs_rsp_valid, 1'b0);
    check("req_ready_idle", obs_req_ready, 1'b1);
  endtask

  task automatic run_txn(input txn_t x, input int delay, input bit queue, input txn_t q);
    int            exp_cycles, cycles;
    logic [1:0]    exp_status;
    logic [BW-1:0] exp_data;
    model(x, sel ? TO_B : TO_A, sel ? ERR_B : ERR_A, exp_cycles, exp_status, exp_data);
    drive_req(x);
    access_phase(x, cycles);
    check("access_cycles", 64'(cycles), 64'(exp_cycles));
    respond(exp_status, exp_data, delay, queue, q);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    none = mk(1'b0, '0, '0, '0, 1'b1, 1, 2'b00, '0);
    sel = 1'b0; i_rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_address = '0; req_write_data = '0; req_strobe = '0; rsp_ready = 1'b0;
    reg_match = 1'b1; reg_ready = 1'b1; reg_status = 2'b01; reg_read_data = '1;
    repeat (3) @(negedge i_clk);
    check_reset_state();
    sel = 1'b1;
    check_reset_state();
    i_rst = 1'b0;

    phase = "read_okay";
    sel = 1'b0;
    run_txn(mk(1'b0, 8'h04, 32'h0, 4'b0000, 1'b1, 1, 2'b00, 32'hDEAD_BEEF), 0, 1'b0, none);

    phase = "write_stall";
    sel = 1'b1;
    run_txn(mk(1'b1, 8'h07, 32'h1234_5678, 4'b0011, 1'b1, 6, 2'b00, 32'hFFFF_0000), 0, 1'b0, none);

    phase = "decode_error";
    sel = 1'b0;
    run_txn(mk(1'b0, 8'h20, 32'h0, 4'b0101, 1'b0, 1, 2'b00, 32'h1111_2222), 0, 1'b0, none);

    phase = "timeout_t4";
    run_txn(mk(1'b0, 8'h08, 32'h0, 4'b0000, 1'b1, 1000, 2'b00, 32'h5555_AAAA), 0, 1'b0, none);

    phase = "ready_at_boundary";
    run_txn(mk(1'b0, 8'h0C, 32'h0, 4'b0000, 1'b1, 4, 2'b01, 32'h0F0F_0F0F), 0, 1'b0, none);

    phase = "no_timeout_t0";
    sel = 1'b1;
    run_txn(mk(1'b0, 8'h10, 32'h0, 4'b0000, 1'b1, 100, 2'b00, 32'hCAFE_F00D), 0, 1'b0, none);

    phase = "backpressure";
    sel = 1'b0;
    nxt = mk(1'b1, 8'h13, 32'hA5A5_5A5A, 4'b1100, 1'b1, 2, 2'b01, 32'h0);
    run_txn(mk(1'b0, 8'h18, 32'h0, 4'b0000, 1'b1, 2, 2'b00, 32'h7654_3210), 3, 1'b1, nxt);
    phase = "queued_request";
    run_txn(nxt, 0, 1'b0, none);

    phase = "reset_in_access";
    drive_req(mk(1'b1, 8'h2A, 32'h0BAD_CAFE, 4'b1111, 1'b1, 1000, 2'b00, 32'h0));
    check("reg_valid_pre_rst", obs_reg_valid, 1'b1);
    reg_ready = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check_reset_state();
    i_rst = 1'b0;
    run_txn(mk(1'b0, 8'h30, 32'h0, 4'b0000, 1'b1, 2, 2'b00, 32'h1357_9BDF), 0, 1'b0, none);

    phase = "reset_in_respond";
    t = mk(1'b0, 8'h34, 32'h0, 4'b0000, 1'b1, 1, 2'b01, 32'h2468_ACE0);
    drive_req(t);
    access_phase(t, cycles);
    check("access_cycles", 64'(cycles), 64'd1);
    check("rsp_valid_pre_rst", obs_rsp_valid, 1'b1);
    i_rst = 1'b1;
    @(negedge i_clk);
    check_reset_state();
    i_rst = 1'b0;
    @(negedge i_clk);
    check("no_partial_rsp", obs_rsp_valid, 1'b0);
    run_txn(mk(1'b0, 8'h38, 32'h0, 4'b0000, 1'b1, 1, 2'b00, 32'h8000_0001), 0, 1'b0, none);

    phase = "random";
    for (int i = 0; i < 24; i++) begin
      sel = 1'(i % 2);
      t = mk(1'($urandom), AW'($urandom), BW'($urandom), SW'($urandom),
             ($urandom_range(0, 4) != 0), int'($urandom_range(1, 6)),
             2'($urandom), BW'($urandom));
      run_txn(t, int'($urandom_range(0, 2)), 1'b0, none);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rggen_native_bus_adapter.md
Name: rggen_native_bus_adapter

Overview:
- Upstream neighbour of the register blocks. Accepts host read/write requests on a valid/ready channel and drives one access at a time onto the flat register bus. The register bus fans out to all direct and indirect registers.
- Collects the aggregated ready/status/read-data back from the registers, applies decode-error and timeout policy, and returns a buffered response on a valid/ready channel.

Parameters:
- ADDRESS_WIDTH, 8, byte address width of host and register bus
- BUS_WIDTH, 32, data width; must be a power of two and at least 8
- TIMEOUT_CYCLES, 64, maximum number of cycles to wait for i_reg_ready; 0 disables the timeout
- ERROR_READ_DATA, '0, read data returned with any error response

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_req_valid  input  1  host request valid
- o_req_ready  output  1  host request accepted
- i_req_write  input  1  1 = write, 0 = read
- i_req_address  input  ADDRESS_WIDTH  byte address
- i_req_write_data  input  BUS_WIDTH  write data
- i_req_strobe  input  BUS_WIDTH/8  byte enables (writes only)
- o_rsp_valid  output  1  response valid
- i_rsp_ready  input  1  host accepts response
- o_rsp_status  output  2  rggen_status_t
- o_rsp_read_data  output  BUS_WIDTH  read data
- o_reg_valid  output  1  register access active
- o_reg_write  output  1  access direction
- o_reg_address  output  ADDRESS_WIDTH  word-aligned address
- o_reg_write_data  output  BUS_WIDTH  registered write data
- o_reg_strobe  output  BUS_WIDTH/8  registered strobe; all-ones on reads
- i_reg_match  input  1  OR of all register address and indirect-index matches
- i_reg_ready  input  1  OR of register readies
- i_reg_status  input  2  aggregated register status
- i_reg_read_data  input  BUS_WIDTH  OR-combined read data

Behaviour:
- Reset: FSM in IDLE. o_req_ready=1, o_rsp_valid=0, o_reg_valid=0, o_reg_write=0. Address, data and strobe outputs 0. o_rsp_status=OKAY, o_rsp_read_data=0. Timeout counter 0.
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid, capture write, address (low log2(BUS_WIDTH/8) bits forced 0), data, and strobe (forced all-ones for reads). Go to ACCESS.
  - o_reg_valid rises the cycle after acceptance.
- ACCESS:
  - o_reg_valid=1; all o_reg_* outputs held stable. o_req_ready=0.
  - Each cycle, evaluate in this priority order:
    1. i_reg_match=0: DECODE_ERROR, read data=ERROR_READ_DATA.
    2. i_reg_ready=1: status=i_reg_status. Read data=i_reg_read_data on reads, 0 on writes.
    3. Counter reaches TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES>0 only): SLAVE_ERROR, read data=ERROR_READ_DATA.
    4. Otherwise: counter increments.
  - Cases 1–3 register the response, drop o_reg_valid on the next edge, clear the counter, and go to RESPOND.
  - Minimum latency from request accept to o_rsp_valid is 2 cycles.
- RESPOND:
  - o_rsp_valid=1; status and data held stable until i_rsp_ready.
  - On handshake, go to IDLE. o_req_ready is 1 in the following cycle, so there is no same-cycle request/response bypass.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- A request is never dropped: i_req_valid held while o_req_ready=0 is only accepted after return to IDLE.
- i_rst asserted in any state aborts the access:
  - o_reg_valid=0 and o_rsp_valid=0 on the next edge.
  - The pending response is discarded; no partial response is emitted.
- i_reg_ready together with i_reg_match=0 in the same cycle is reported as DECODE_ERROR.
- i_reg_* inputs are ignored outside ACCESS.

Decomposition:
- Shared package rggen_rtl_pkg holds:
  - rggen_status_t: OKAY=2'b00, EXOKAY=2'b01, SLAVE_ERROR=2'b10, DECODE_ERROR=2'b11
  - rggen_access_t
  - the FSM state enum
- Sub-module rggen_bus_timeout_counter: enable, clear, expired flag, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Read addr 0x04, i_reg_match=1, i_reg_ready in the first ACCESS cycle, data 0xDEADBEEF -> o_rsp_valid 2 cycles after accept, status OKAY, data 0xDEADBEEF.
- Write addr 0x07 data 0x12345678 strobe 4'b0011 -> o_reg_address 0x04, strobe 0011, data held while ready stalled 5 cycles; then OKAY, read data 0.
- Read addr 0x20 with i_reg_match=0 -> DECODE_ERROR, data=ERROR_READ_DATA, o_reg_valid high for exactly 1 cycle.
- TIMEOUT_CYCLES=4, i_reg_match=1, ready never asserted -> SLAVE_ERROR after 4 ACCESS cycles. Repeat with TIMEOUT_CYCLES=0: waits indefinitely until ready arrives at cycle 100, then OKAY.
- Response backpressure: i_rsp_ready low 3 cycles -> status and data stable, o_req_ready=0. A second request queued on i_req_valid is accepted in the cycle after the handshake.
- i_rst pulsed in ACCESS and in RESPOND -> all outputs at reset values next cycle; a fresh read completes normally.
